// File: rtl/sr_latch_driver_if.sv
// Request/feedback and drive/status bundle between a requester and sr_latch_driver.
// Latency: none, plain wires.
// Backpressure: none in the bundle; the driver drops requests while busy is high.
interface sr_latch_driver_if;
    logic set_req;
    logic clr_req;
    logic err_clr;
    logic q_fb;
    logic s;
    logic r;
    logic busy;
    logic ack;
    logic q_exp;
    logic err;

    // Requester side: issues requests and returns latch Q; observes drives and status.
    modport master (
        output set_req, clr_req, err_clr, q_fb,
        input  s, r, busy, ack, q_exp, err
    );

    // Driver side: consumes requests and feedback; produces drives and status.
    modport slave (
        input  set_req, clr_req, err_clr, q_fb,
        output s, r, busy, ack, q_exp, err
    );
endinterface

// File: rtl/sr_latch_driver.sv
// Turns one-cycle set/clear requests into non-overlapping S/R pulses plus dead time, then checks latch Q.
// Latency: request at edge k -> pulse in cycles k+1..k+PULSE_W, gap after it, ack in cycle k+PULSE_W+GAP_W+1.
// Backpressure: busy high for the whole operation; requests seen while busy are dropped, not queued.
module sr_latch_driver #(
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 2,
    parameter int CNT_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    sr_latch_driver_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_W - 1);

    // Single sequencer: state, counter and every output are registered here.
    // S and R are only ever raised from IDLE and cleared together on the way to GAP,
    // so they can never be high in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bus.s     <= 1'b0;
            bus.r     <= 1'b0;
            bus.busy  <= 1'b0;
            bus.ack   <= 1'b0;
            bus.q_exp <= 1'b0;
            bus.err   <= 1'b0;
        end else begin
            bus.ack <= 1'b0;
            // Clear first so a mismatch at the same edge overrides it below.
            if (bus.err_clr) begin
                bus.err <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    // Clear has priority; a simultaneous set is simply dropped.
                    if (bus.clr_req) begin
                        state     <= PULSE_R;
                        bus.r     <= 1'b1;
                        bus.busy  <= 1'b1;
                        bus.q_exp <= 1'b0;
                    end else if (bus.set_req) begin
                        state     <= PULSE_S;
                        bus.s     <= 1'b1;
                        bus.busy  <= 1'b1;
                        bus.q_exp <= 1'b1;
                    end
                end

                PULSE_S, PULSE_R: begin
                    if (cnt == PULSE_LAST) begin
                        state <= GAP;
                        cnt   <= '0;
                        bus.s <= 1'b0;
                        bus.r <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        bus.busy <= 1'b0;
                        bus.ack  <= 1'b1;
                        // The latch has settled by now; this is the only edge Q is looked at.
                        if (bus.q_fb != bus.q_exp) begin
                            bus.err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: directed scenarios followed by random traffic, all against a timeline model.
// Latency: model works from absolute edge numbers of each accepted request.
// Backpressure: model drops any request that arrives while an operation is in flight.
module tb_sr_latch_driver;
    localparam int PW = 4;
    localparam int GW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sr_latch_driver_if bus ();

    sr_latch_driver #(.PULSE_W(PW), .GAP_W(GW), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural latch plus an override for forcing a wrong Q.
    logic latch_q   = 1'b0;
    logic force_q   = 1'b0;
    logic force_val = 1'b0;
    assign bus.q_fb = force_q ? force_val : latch_q;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Timeline model: an operation is just "accepted at edge m_acc"; everything else is arithmetic on that.
    int   edge_n   = 0;
    int   m_acc    = 0;
    bit   m_active = 0;
    bit   m_set    = 0;
    bit   m_ack    = 0;
    bit   m_qexp   = 0;
    bit   m_err    = 0;

    int   ack_cnt  = 0;
    int   s_cyc    = 0;
    int   r_cyc    = 0;

    task automatic model_edge();
        bit done;
        bit idle;
        edge_n++;
        if (rst) begin
            m_active = 0;
            m_qexp   = 0;
            m_err    = 0;
            m_ack    = 0;
        end else begin
            done  = m_active && (edge_n == m_acc + PW + GW);
            idle  = !m_active;
            m_ack = done;
            if (bus.err_clr) m_err = 0;
            if (done && (bus.q_fb != m_qexp)) m_err = 1;
            if (done) m_active = 0;
            if (idle && (bus.clr_req || bus.set_req)) begin
                m_active = 1;
                m_acc    = edge_n;
                m_set    = !bus.clr_req;
                m_qexp   = m_set;
            end
        end
    endtask

    task automatic check_outputs();
        bit in_pulse;
        in_pulse = m_active && ((edge_n - m_acc) < PW);
        check("s",     32'(bus.s),     32'(in_pulse && m_set));
        check("r",     32'(bus.r),     32'(in_pulse && !m_set));
        check("busy",  32'(bus.busy),  32'(m_active));
        check("ack",   32'(bus.ack),   32'(m_ack));
        check("q_exp", 32'(bus.q_exp), 32'(m_qexp));
        check("err",   32'(bus.err),   32'(m_err));
        check("s_and_r", 32'(bus.s & bus.r), 32'd0);
    endtask

    // One clock: inputs are applied at the falling edge, outputs checked at the next falling edge.
    task automatic cyc(input bit rs, input bit st, input bit cl, input bit ec);
        rst         = rs;
        bus.set_req = st;
        bus.clr_req = cl;
        bus.err_clr = ec;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        if (bus.ack) ack_cnt++;
        if (bus.s)   s_cyc++;
        if (bus.r)   r_cyc++;
        if (bus.s)      latch_q = 1'b1;
        else if (bus.r) latch_q = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic clr_stats();
        ack_cnt = 0;
        s_cyc   = 0;
        r_cyc   = 0;
    endtask

    initial begin
        rst         = 1'b1;
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
        bus.err_clr = 1'b0;
        @(negedge clk);

        // Reset then a plain set.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        clr_stats();
        cyc(0, 1, 0, 0);
        idle(7);
        check("t1_acks", 32'(ack_cnt), 32'd1);
        check("t1_s_cycles", 32'(s_cyc), 32'(PW));
        check("t1_r_cycles", 32'(r_cyc), 32'd0);
        check("t1_q_exp", 32'(bus.q_exp), 32'd1);

        // Simultaneous set and clear: clear wins.
        clr_stats();
        cyc(0, 1, 1, 0);
        idle(8);
        check("t2_r_cycles", 32'(r_cyc), 32'(PW));
        check("t2_s_cycles", 32'(s_cyc), 32'd0);
        check("t2_acks", 32'(ack_cnt), 32'd1);
        check("t2_q_exp", 32'(bus.q_exp), 32'd0);

        // Clear during the second S cycle is ignored.
        clr_stats();
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        idle(8);
        check("t3_r_cycles", 32'(r_cyc), 32'd0);
        check("t3_acks", 32'(ack_cnt), 32'd1);
        check("t3_q_exp", 32'(bus.q_exp), 32'd1);

        // Forced mismatch, sticky error, clear, then clear colliding with a new mismatch.
        force_q   = 1'b1;
        force_val = 1'b0;
        cyc(0, 1, 0, 0);
        idle(6);
        check("t4_err_set", 32'(bus.err), 32'd1);
        idle(3);
        check("t4_err_sticky", 32'(bus.err), 32'd1);
        cyc(0, 0, 0, 1);
        check("t4_err_cleared", 32'(bus.err), 32'd0);
        cyc(0, 1, 0, 0);
        idle(PW + GW - 1);
        cyc(0, 0, 0, 1);
        check("t4_set_wins", 32'(bus.err), 32'd1);
        force_q = 1'b0;
        cyc(0, 0, 0, 1);
        check("t4_err_cleared2", 32'(bus.err), 32'd0);

        // Reset during the third R cycle.
        clr_stats();
        cyc(0, 0, 1, 0);
        idle(2);
        cyc(1, 0, 0, 0);
        check("t5_r", 32'(bus.r), 32'd0);
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_q_exp", 32'(bus.q_exp), 32'd0);
        idle(8);
        check("t5_acks", 32'(ack_cnt), 32'd0);

        // Back-to-back: clear issued in the ack cycle.
        cyc(0, 1, 0, 0);
        idle(PW + GW);
        check("t6_ack_cycle", 32'(bus.ack), 32'd1);
        cyc(0, 0, 1, 0);
        check("t6_r_next", 32'(bus.r), 32'd1);
        check("t6_ack_gone", 32'(bus.ack), 32'd0);
        idle(8);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 31) == 0) begin
                force_q   = ~force_q;
                force_val = 1'($urandom_range(0, 1));
            end
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
Synchronous front-end controller that produces the S and R drive pulses for the cross-coupled NOR SR latch cell. It converts single-cycle set/clear requests into fixed-width, never-overlapping S/R pulses, each followed by a dead time. At the end of the dead time it checks the latch's Q output against the expected state. It sits directly upstream of the latch, and Q of the latch returns to this block as Q_FB.

Parameters:
PULSE_W, 4, number of cycles S or R is held high per operation (>=1)
GAP_W, 2, dead-time cycles with S=R=0 after each pulse, before Q_FB is checked (>=1)
CNT_W, 4, width of the internal cycle counter; must hold max(PULSE_W, GAP_W)

Ports:
CLK  input  1  single clock; all state changes on rising edge
RST  input  1  reset, synchronous, active-high
SET_REQ  input  1  request to set latch (Q=1); sampled only in IDLE
CLR_REQ  input  1  request to clear latch (Q=0); sampled only in IDLE
ERR_CLR  input  1  clears sticky ERR
Q_FB  input  1  Q output of the SR latch
S  output  1  latch set drive, registered
R  output  1  latch reset drive, registered
BUSY  output  1  high while an operation is in progress (pulse or gap)
ACK  output  1  one-cycle pulse: operation complete, Q_FB checked
Q_EXP  output  1  expected latch state after the last accepted request
ERR  output  1  sticky: Q_FB mismatched Q_EXP at a check

Behaviour:
- Reset (RST high at an edge): state IDLE, counter 0, S=R=BUSY=ACK=Q_EXP=ERR=0. RST has priority over everything, including mid-pulse. S/R drop to 0 in the cycle after the reset edge.
- States: IDLE, PULSE_S, PULSE_R, GAP. All outputs are registered.
- IDLE:
  - CLR_REQ=1 at edge -> PULSE_R; Q_EXP<=0.
  - Else SET_REQ=1 -> PULSE_S; Q_EXP<=1.
  - If both are high, CLR wins and SET is dropped (no ACK for it).
  - Neither high -> stay in IDLE.
- PULSE_S/PULSE_R:
  - S (resp. R)=1 and BUSY=1 for exactly PULSE_W cycles, then -> GAP.
  - S and R are never high in the same cycle, under any input sequence.
- GAP:
  - S=R=0, BUSY=1 for GAP_W cycles.
  - At the edge ending the last GAP cycle: state->IDLE, BUSY<=0, ACK<=1 for one cycle.
  - At that same edge, if Q_FB!=Q_EXP, ERR<=1.
- Timing: request sampled at edge k -> S/R high in cycles k+1..k+PULSE_W -> gap in cycles k+PULSE_W+1..k+PULSE_W+GAP_W -> ACK in cycle k+PULSE_W+GAP_W+1.
- Back-to-back: a new request may be accepted in the ACK cycle, since the state is IDLE. ACK and the new pulse's first cycle do not overlap; the pulse starts the following cycle.
- Requests while BUSY=1 are ignored, not queued.
- Redundant request (SET_REQ when Q_EXP=1, or CLR_REQ when Q_EXP=0) still runs a full pulse+gap+check.
- ERR:
  - Set only at a check.
  - Cleared by ERR_CLR at an edge.
  - If a check mismatch and ERR_CLR occur on the same edge, set wins (ERR=1).
- Q_FB is used only at the check edge; its value at other times is don't-care (the latch is mid-transition during the pulse).
- Counter counts from 0 to PULSE_W-1 and then from 0 to GAP_W-1. It reloads on each state entry and never wraps inside a state.

Test Plan:
1. Reset and set: RST for 2 cycles, then SET_REQ at edge 3, Q_FB tied to S-driven latch model (defaults) -> S=1 in cycles 4-7, R=0 throughout, gap in cycles 8-9, ACK=1 in cycle 10 only, Q_EXP=1, ERR=0, BUSY=1 in cycles 4-9.
2. Simultaneous: SET_REQ=CLR_REQ=1 in IDLE -> R pulse for 4 cycles, S stays 0, Q_EXP=0, exactly one ACK.
3. Ignore while busy: SET_REQ, then CLR_REQ during cycle 2 of the S pulse -> no R pulse follows, one ACK, Q_EXP=1.
4. Mismatch: SET_REQ with Q_FB forced 0 -> ERR=1 in the ACK cycle and stays 1. Then pulse ERR_CLR for 1 cycle -> ERR=0. Repeat with ERR_CLR asserted on the check edge -> ERR=1.
5. Reset mid-operation: RST during cycle 3 of the R pulse -> R=0 next cycle, BUSY=0, Q_EXP=0, no ACK issued.
6. Back-to-back: SET_REQ, then CLR_REQ in the ACK cycle -> R rises in the next cycle. S/R have no overlap and no idle gap beyond the ACK cycle. Exhaustive random requests with an S&R==1 assertion -> never fires.
